// File: rtl/vga_dac_pkg.sv
// Shared definitions for the VGA DAC register front end: register
// selects, FSM encoding and the palette entry layout.
package vga_dac_pkg;

    // Register select values on the 2-bit bus address
    localparam logic [1:0] DAC_MASK = 2'd0;   // 0x3C6 PEL mask
    localparam logic [1:0] DAC_RIDX = 2'd1;   // 0x3C7 read index / DAC state
    localparam logic [1:0] DAC_WIDX = 2'd2;   // 0x3C8 write index
    localparam logic [1:0] DAC_DATA = 2'd3;   // 0x3C9 data

    // Each palette entry is an R, G, B triple
    localparam int         RGB_COMPONENTS = 3;
    localparam logic [1:0] LAST_COMP      = 2'(RGB_COMPONENTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } dac_state_t;

endpackage

// File: rtl/vga_dac_port_if.sv
// Host register bus between the system bus bridge and the DAC port.
// req is held by the master until ack pulses for one cycle.
interface vga_dac_port_if;
    logic       req;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ack;

    modport master (output req, output we, output addr, output wdata,
                    input  rdata, input ack);
    modport slave  (input  req, input we, input addr, input wdata,
                    output rdata, output ack);
endinterface

// File: rtl/dac_index_tracker.sv
// Shadow copy of the palette write index: counts R/G/B components of
// 0x3C9 writes and advances the entry index after every blue component.
module dac_index_tracker
    import vga_dac_pkg::*;
(
    input  logic       clock_i,
    input  logic       reset_ni,
    input  logic       load,
    input  logic [7:0] load_index,
    input  logic       advance,
    output logic [7:0] windex
);

    logic [7:0] index_reg;
    logic [1:0] comp_reg;

    // Index/component counter; an index load restarts at the red component
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            index_reg <= 8'd0;
            comp_reg  <= 2'd0;
        end else if (load) begin
            index_reg <= load_index;
            comp_reg  <= 2'd0;
        end else if (advance) begin
            if (comp_reg == LAST_COMP) begin
                comp_reg  <= 2'd0;
                index_reg <= index_reg + 8'd1;
            end else begin
                comp_reg  <= comp_reg + 2'd1;
            end
        end
    end

    assign windex = index_reg;

endmodule

// File: rtl/vga_dac_port.sv
// VGA DAC register front end: decodes 0x3C6..0x3C9 accesses from the
// req/ack bus into palette strobes, paces 0x3C9 reads against the
// palette read latency and shadows the write index for 0x3C8 reads.
module vga_dac_port
    import vga_dac_pkg::*;
#(
    parameter int         RD_LATENCY    = 3,
    parameter logic [7:0] PEL_MASK_INIT = 8'hFF
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    vga_dac_port_if.slave      bus,
    output logic               pal_read_o,
    output logic               pal_write_o,
    output logic               pal_rd_addr_set_o,
    output logic               pal_wr_addr_set_o,
    output logic [7:0]         pal_raddr_o,
    output logic [7:0]         pal_waddr_o,
    output logic [7:0]         pal_data_o,
    input  logic [7:0]         pal_data_i,
    input  logic [1:0]         pal_readmode_i,
    output logic [7:0]         pel_mask_o
);

    localparam logic [3:0] SETTLE_LOAD = 4'(RD_LATENCY);

    dac_state_t state_reg, state_next;
    logic       we_reg, we_next;
    logic [1:0] addr_reg, addr_next;
    logic [7:0] wdata_reg, wdata_next;
    logic [3:0] settle_reg, settle_next;
    logic       ack_reg, ack_next;
    logic [7:0] rdata_reg, rdata_next;
    logic       read_reg, read_next;
    logic       write_reg, write_next;
    logic       rd_set_reg, rd_set_next;
    logic       wr_set_reg, wr_set_next;
    logic [7:0] raddr_reg, raddr_next;
    logic [7:0] waddr_reg, waddr_next;
    logic [7:0] pdata_reg, pdata_next;
    logic [7:0] mask_reg, mask_next;
    logic       idx_load;
    logic       idx_advance;
    logic [7:0] windex;

    dac_index_tracker u_index (
        .clock_i    (clock_i),
        .reset_ni   (reset_ni),
        .load       (idx_load),
        .load_index (wdata_reg),
        .advance    (idx_advance),
        .windex     (windex)
    );

    // Next-state and next-output decode; all outputs leave through registers
    always_comb begin
        state_next  = state_reg;
        we_next     = we_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        settle_next = (settle_reg != 4'd0) ? settle_reg - 4'd1 : 4'd0;
        ack_next    = 1'b0;
        rdata_next  = rdata_reg;
        read_next   = 1'b0;
        write_next  = 1'b0;
        rd_set_next = 1'b0;
        wr_set_next = 1'b0;
        raddr_next  = raddr_reg;
        waddr_next  = waddr_reg;
        pdata_next  = pdata_reg;
        mask_next   = mask_reg;
        idx_load    = 1'b0;
        idx_advance = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.req) begin
                    we_next    = bus.we;
                    addr_next  = bus.addr;
                    wdata_next = bus.wdata;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!we_reg && addr_reg == DAC_DATA) begin
                    // Data reads must wait for the palette pipeline to settle
                    state_next = ST_WAIT;
                end else begin
                    ack_next   = 1'b1;
                    state_next = ST_DONE;
                    if (we_reg) begin
                        case (addr_reg)
                            DAC_MASK: mask_next = wdata_reg;
                            DAC_RIDX: begin
                                raddr_next  = wdata_reg;
                                rd_set_next = 1'b1;
                                settle_next = SETTLE_LOAD;
                            end
                            DAC_WIDX: begin
                                waddr_next  = wdata_reg;
                                wr_set_next = 1'b1;
                                idx_load    = 1'b1;
                            end
                            default: begin
                                pdata_next  = wdata_reg;
                                write_next  = 1'b1;
                                idx_advance = 1'b1;
                            end
                        endcase
                    end else begin
                        case (addr_reg)
                            DAC_MASK: rdata_next = mask_reg;
                            DAC_RIDX: rdata_next = {6'b0, pal_readmode_i};
                            default:  rdata_next = windex;
                        endcase
                    end
                end
            end
            ST_WAIT: begin
                if (settle_reg == 4'd0) begin
                    rdata_next  = pal_data_i;
                    ack_next    = 1'b1;
                    read_next   = 1'b1;
                    settle_next = SETTLE_LOAD;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                // A request still held high must not execute twice
                if (!bus.req) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any access without an ack
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg  <= ST_IDLE;
            we_reg     <= 1'b0;
            addr_reg   <= 2'd0;
            wdata_reg  <= 8'd0;
            settle_reg <= 4'd0;
            ack_reg    <= 1'b0;
            rdata_reg  <= 8'd0;
            read_reg   <= 1'b0;
            write_reg  <= 1'b0;
            rd_set_reg <= 1'b0;
            wr_set_reg <= 1'b0;
            raddr_reg  <= 8'd0;
            waddr_reg  <= 8'd0;
            pdata_reg  <= 8'd0;
            mask_reg   <= PEL_MASK_INIT;
        end else begin
            state_reg  <= state_next;
            we_reg     <= we_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            settle_reg <= settle_next;
            ack_reg    <= ack_next;
            rdata_reg  <= rdata_next;
            read_reg   <= read_next;
            write_reg  <= write_next;
            rd_set_reg <= rd_set_next;
            wr_set_reg <= wr_set_next;
            raddr_reg  <= raddr_next;
            waddr_reg  <= waddr_next;
            pdata_reg  <= pdata_next;
            mask_reg   <= mask_next;
        end
    end

    assign bus.ack           = ack_reg;
    assign bus.rdata         = rdata_reg;
    assign pal_read_o        = read_reg;
    assign pal_write_o       = write_reg;
    assign pal_rd_addr_set_o = rd_set_reg;
    assign pal_wr_addr_set_o = wr_set_reg;
    assign pal_raddr_o       = raddr_reg;
    assign pal_waddr_o       = waddr_reg;
    assign pal_data_o        = pdata_reg;
    assign pel_mask_o        = mask_reg;

endmodule
